// File: rtl/dram_refresh_defs.sv
// dram_refresh_defs
//   Shared definitions for the DRAM refresh arbiter: FSM state encoding and
//   the default timing parameters (64 ms / 4096 rows at 25 MHz gives a
//   refresh tick every 390 cycles).
//   No ports; imported by refresh_timer and dram_refresh_arbiter.
package dram_refresh_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_REF  = 2'd2
  } arb_state_t;

  localparam int DEF_INTERVAL = 390;
  localparam int DEF_TWIDTH   = 9;
  localparam int DEF_MAX_DEBT = 8;
  localparam int DEF_URGENT   = 4;

endpackage

// File: rtl/refresh_timer.sv
// refresh_timer
//   Free-running interval timer producing a one-cycle TICK every INTERVAL
//   cycles. The first TICK is high on the INTERVAL-th cycle after RESET
//   is released.
// Ports:
//   CLK   - clock, rising edge
//   RESET - synchronous, active-high reset (reloads the timer)
//   TICK  - one-cycle refresh tick
module refresh_timer
  import dram_refresh_defs::*;
#(
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int TWIDTH   = DEF_TWIDTH
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  localparam logic [TWIDTH-1:0] RELOAD = TWIDTH'(INTERVAL - 1);

  logic [TWIDTH-1:0] count;

  // Count down from INTERVAL-1; the cycle spent at zero is the tick cycle,
  // and the reload happens on that same edge, so the period is INTERVAL.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - TWIDTH'(1);
    end
  end

  assign TICK = (count == '0);

endmodule

// File: rtl/dram_refresh_arbiter.sv
// dram_refresh_arbiter
//   Arbitrates the DRAM sequencer between CPU accesses and periodic refresh.
//   Refresh ticks accumulate as "debt"; the CPU is preferred until the debt
//   reaches URGENT, after which refresh wins the next IDLE decision. Grants
//   are never preempted and each grant is followed by at least one IDLE
//   cycle.
// Ports:
//   CLK          - clock, rising edge
//   RESET        - synchronous, active-high reset
//   CPU_REQ      - CPU access request (level)
//   MEM_DONE     - one-cycle pulse ending the granted operation
//   CPU_GNT      - CPU owns the sequencer (registered)
//   REF_GNT      - refresh owns the sequencer (registered)
//   REF_PENDING  - current refresh debt, zero-extended to 4 bits
//   REF_OVERFLOW - sticky: a refresh tick was lost at saturation
module dram_refresh_arbiter
  import dram_refresh_defs::*;
#(
  parameter int INTERVAL = DEF_INTERVAL,
  parameter int TWIDTH   = DEF_TWIDTH,
  parameter int MAX_DEBT = DEF_MAX_DEBT,
  parameter int URGENT   = DEF_URGENT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CPU_REQ,
  input  logic       MEM_DONE,
  output logic       CPU_GNT,
  output logic       REF_GNT,
  output logic [3:0] REF_PENDING,
  output logic       REF_OVERFLOW
);

  localparam logic [3:0] MAX_D = 4'(MAX_DEBT);
  localparam logic [3:0] URG_D = 4'(URGENT);

  arb_state_t state;
  arb_state_t next_state;
  logic       tick;
  logic       take_ref;
  logic [3:0] debt;

  refresh_timer #(
    .INTERVAL(INTERVAL),
    .TWIDTH  (TWIDTH)
  ) u_timer (
    .CLK  (CLK),
    .RESET(RESET),
    .TICK (tick)
  );

  // IDLE decision priority: urgent refresh, then CPU, then any owed
  // refresh. Busy states only leave on MEM_DONE, which always lands in
  // IDLE so a fresh decision is made between consecutive grants.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (debt >= URG_D) begin
          next_state = ST_REF;
        end else if (CPU_REQ) begin
          next_state = ST_CPU;
        end else if (debt != 4'd0) begin
          next_state = ST_REF;
        end
      end
      ST_CPU, ST_REF: begin
        if (MEM_DONE) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A refresh is consumed on the IDLE->REF transition edge.
  assign take_ref = (state == ST_IDLE) && (next_state == ST_REF);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grants are registered from next_state so they mirror the state
  // register exactly while coming straight out of flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CPU_GNT <= 1'b0;
      REF_GNT <= 1'b0;
    end else begin
      CPU_GNT <= (next_state == ST_CPU);
      REF_GNT <= (next_state == ST_REF);
    end
  end

  // A tick and a consumed refresh on the same edge cancel out. A tick that
  // would push debt past MAX_DEBT is dropped and remembered in the sticky
  // overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      debt         <= 4'd0;
      REF_OVERFLOW <= 1'b0;
    end else if (tick && !take_ref) begin
      if (debt == MAX_D) begin
        REF_OVERFLOW <= 1'b1;
      end else begin
        debt <= debt + 4'd1;
      end
    end else if (take_ref && !tick) begin
      debt <= debt - 4'd1;
    end
  end

  assign REF_PENDING = debt;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// tb_dram_refresh_arbiter
//   Self-checking bench for dram_refresh_arbiter (INTERVAL=8, MAX_DEBT=4,
//   URGENT=2). A behavioural model tracks who owns the sequencer, the
//   refresh debt and the overflow flag; ticks are derived from the number of
//   cycles since reset release.
module tb_dram_refresh_arbiter;

  localparam int INTERVAL = 8;
  localparam int TWIDTH   = 4;
  localparam int MAX_DEBT = 4;
  localparam int URGENT   = 2;

  localparam int OWN_NONE = 0;
  localparam int OWN_CPU  = 1;
  localparam int OWN_REF  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpuReq = 1'b0;
  logic       memDone = 1'b0;
  logic       cpuGnt;
  logic       refGnt;
  logic [3:0] refPending;
  logic       refOverflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mOwner = OWN_NONE;
  int mDebt  = 0;
  int mCyc   = 0;
  int mAge   = 0;
  bit mOvf   = 1'b0;

  int refRises[$];
  bit prevRef = 1'b0;

  always #5 clk = ~clk;

  dram_refresh_arbiter #(
    .INTERVAL(INTERVAL),
    .TWIDTH  (TWIDTH),
    .MAX_DEBT(MAX_DEBT),
    .URGENT  (URGENT)
  ) dut (
    .CLK         (clk),
    .RESET       (reset),
    .CPU_REQ     (cpuReq),
    .MEM_DONE    (memDone),
    .CPU_GNT     (cpuGnt),
    .REF_GNT     (refGnt),
    .REF_PENDING (refPending),
    .REF_OVERFLOW(refOverflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the rising edge,
  // then compare all outputs on the following falling edge.
  task automatic applyStimulus(input bit rst, input bit req, input bit done);
    int nOwner;
    int nDebt;
    bit tickNow;
    bit refNow;
    bit cpuNow;
    reset   = rst;
    cpuReq  = req;
    memDone = done;
    if (rst) begin
      nOwner = OWN_NONE;
      nDebt  = 0;
      mOvf   = 1'b0;
      mCyc   = 0;
    end else begin
      mCyc++;
      tickNow = ((mCyc % INTERVAL) == 0);
      refNow  = (mOwner == OWN_NONE) && ((mDebt >= URGENT) || (!req && mDebt > 0));
      cpuNow  = (mOwner == OWN_NONE) && !refNow && req;
      nDebt   = mDebt + (tickNow ? 1 : 0) - (refNow ? 1 : 0);
      if (nDebt > MAX_DEBT) begin
        nDebt = MAX_DEBT;
        mOvf  = 1'b1;
      end
      if (mOwner != OWN_NONE) nOwner = done ? OWN_NONE : mOwner;
      else if (refNow)        nOwner = OWN_REF;
      else if (cpuNow)        nOwner = OWN_CPU;
      else                    nOwner = OWN_NONE;
    end
    @(posedge clk);
    @(negedge clk);
    mAge   = (nOwner == mOwner) ? mAge + 1 : 0;
    mOwner = nOwner;
    mDebt  = nDebt;
    checkOutput("cpu_gnt", 32'(cpuGnt), 32'(mOwner == OWN_CPU));
    checkOutput("ref_gnt", 32'(refGnt), 32'(mOwner == OWN_REF));
    checkOutput("ref_pending", 32'(refPending), 32'(mDebt));
    checkOutput("ref_overflow", 32'(refOverflow), 32'(mOvf));
    if (refGnt && !prevRef) refRises.push_back(mCyc);
    prevRef = refGnt;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  // Grants are finished with MEM_DONE two cycles after they appear.
  // reqMode: 0 = no request, 1 = request held, 2 = random request.
  task automatic serviceCycles(input int n, input int reqMode);
    bit req;
    bit done;
    for (int i = 0; i < n; i++) begin
      req  = (reqMode == 2) ? bit'($urandom_range(0, 1)) : (reqMode == 1);
      done = (mOwner != OWN_NONE) && (mAge >= 2);
      applyStimulus(1'b0, req, done);
    end
  endtask

  initial begin
    int guard;

    doReset();

    // Idle refresh: first grant INTERVAL+1 cycles after release, then
    // one every INTERVAL cycles, debt drained back to zero.
    refRises.delete();
    serviceCycles(4 * INTERVAL + 4, 0);
    checkOutput("idle_rise_count", 32'(refRises.size()), 32'(4));
    checkOutput("first_ref_latency", (refRises.size() > 0) ? 32'(refRises[0]) : 32'hFFFF_FFFF,
                32'(INTERVAL + 1));
    checkOutput("ref_period", (refRises.size() > 1) ? 32'(refRises[1] - refRises[0]) : 32'd0,
                32'(INTERVAL));
    checkOutput("idle_debt_drained", 32'(refPending), 32'd0);

    // CPU priority: with debt 1 the CPU still wins the IDLE decision.
    doReset();
    serviceCycles(INTERVAL + 1, 1);
    checkOutput("cpu_over_debt1", 32'({cpuGnt, refGnt}), 32'(2'b10));
    checkOutput("cpu_over_debt1_pending", 32'(refPending), 32'd1);

    // Urgency: hold the CPU grant until debt reaches URGENT, release it,
    // expect one IDLE cycle and then refresh despite CPU_REQ.
    doReset();
    guard = 0;
    while (mDebt < URGENT && guard < 10 * INTERVAL) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("urg_debt_reached", 32'(refPending), 32'(URGENT));
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("urg_idle_gap", 32'({cpuGnt, refGnt}), 32'(2'b00));
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("urg_ref_wins", 32'({cpuGnt, refGnt}), 32'(2'b01));

    // Overflow: CPU grant held for 40 cycles saturates the debt.
    doReset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ovf_saturated", 32'(refPending), 32'(MAX_DEBT));
    checkOutput("ovf_set", 32'(refOverflow), 32'd1);
    serviceCycles(3 * INTERVAL, 2);
    checkOutput("ovf_sticky", 32'(refOverflow), 32'd1);

    // Reset during a refresh grant clears everything on that edge and
    // restarts the tick period.
    guard = 0;
    while (!refGnt && guard < 4 * INTERVAL) begin
      serviceCycles(1, 0);
      guard++;
    end
    checkOutput("refgnt_before_reset", 32'(refGnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rst_refgnt", 32'(refGnt), 32'd0);
    checkOutput("rst_pending", 32'(refPending), 32'd0);
    checkOutput("rst_overflow", 32'(refOverflow), 32'd0);
    serviceCycles(INTERVAL - 1, 0);
    checkOutput("no_early_tick", 32'(refPending), 32'd0);
    serviceCycles(1, 0);
    checkOutput("tick_after_reset", 32'(refPending), 32'd1);

    // Tick and IDLE->REF on the same edge with debt 1: debt stays 1.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    while (mCyc < 2 * INTERVAL - 2) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("coinc_ref", 32'({cpuGnt, refGnt}), 32'(2'b01));
    checkOutput("coinc_debt_held", 32'(refPending), 32'd1);

    // Random traffic, including stray MEM_DONE pulses and occasional resets.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus(bit'($urandom_range(0, 99) == 0),
                    bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dram_refresh_arbiter.md
DRAM_REFRESH_ARBITER -- requirements
Module: dram_refresh_arbiter

Interface
REQ-001 SHALL have parameter INTERVAL, default 390, meaning cycles per refresh tick (64 ms / 4096 rows at 25 MHz).
REQ-002 SHALL have parameter TWIDTH, default 9, meaning the interval timer width; INTERVAL SHALL satisfy INTERVAL <= 2^TWIDTH.
REQ-003 SHALL have parameter MAX_DEBT, default 8, meaning the saturation limit of owed refreshes.
REQ-004 SHALL have parameter URGENT, default 4, meaning the debt level at which refresh preempts the CPU; 1 <= URGENT <= MAX_DEBT.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port CPU_REQ, input, 1 bit: CPU memory access request (level).
REQ-008 SHALL have port MEM_DONE, input, 1 bit: one-cycle pulse from the DRAM sequencer marking the end of the granted operation.
REQ-009 SHALL have port CPU_GNT, output, 1 bit: CPU owns the DRAM sequencer.
REQ-010 SHALL have port REF_GNT, output, 1 bit: refresh owns the DRAM sequencer.
REQ-011 SHALL have port REF_PENDING, output, 4 bits: current refresh debt.
REQ-012 SHALL have port REF_OVERFLOW, output, 1 bit: sticky flag indicating a refresh was lost.

Function
REQ-013 Interval timer SHALL load INTERVAL-1 and decrement each cycle; at 0 it SHALL assert internal tick for one cycle and reload INTERVAL-1, giving a tick period of exactly INTERVAL cycles.
REQ-014 The first tick SHALL occur on the INTERVAL-th cycle after RESET deasserts.
REQ-015 Debt counter SHALL add 1 on tick and subtract 1 on the cycle the FSM moves IDLE->REF.
REQ-016 When tick and decrement coincide, debt SHALL be unchanged.
REQ-017 Debt SHALL saturate at MAX_DEBT; a tick while debt==MAX_DEBT with no coincident decrement SHALL set REF_OVERFLOW, which holds until RESET.
REQ-018 Debt SHALL never go below 0; the FSM SHALL enter REF only when debt>0.
REQ-019 FSM states SHALL be IDLE, CPU and REF.
REQ-020 From IDLE, the FSM SHALL take the first matching rule: debt>=URGENT -> REF; CPU_REQ -> CPU; debt>0 -> REF; else stay in IDLE.
REQ-021 In CPU and REF, the FSM SHALL hold until MEM_DONE, then return to IDLE; each grant is followed by at least one IDLE cycle.
REQ-022 CPU_GNT SHALL equal (state==CPU) and REF_GNT SHALL equal (state==REF); both SHALL be registered and never high together.
REQ-023 Grants SHALL assert the cycle after the IDLE decision, i.e. 1-cycle request-to-grant latency.
REQ-024 CPU_REQ deasserting during CPU SHALL be ignored; the grant holds until MEM_DONE.
REQ-025 MEM_DONE in IDLE SHALL be ignored.
REQ-026 A current grant SHALL never be preempted; urgency applies only at the IDLE decision.
REQ-027 REF_PENDING SHALL show the registered debt, zero-extended to 4 bits; MAX_DEBT <= 15.

Reset
REQ-028 While RESET is high on a clock edge, the FSM SHALL go to IDLE, CPU_GNT and REF_GNT to 0, debt to 0, REF_OVERFLOW to 0, and the timer to INTERVAL-1.
REQ-029 RESET SHALL take precedence over tick, MEM_DONE and CPU_REQ, including mid-grant; grants SHALL drop on that edge.

Structure
REQ-030 State encodings (IDLE=0, CPU=1, REF=2) and default INTERVAL/MAX_DEBT/URGENT SHALL live in a shared include file, dram_refresh_defs.
REQ-031 The interval timer (REQ-013/014) SHALL be a sub-module refresh_timer with parameters INTERVAL and TWIDTH, ports CLK, RESET and TICK.
REQ-032 Debt counter and FSM SHALL reside in dram_refresh_arbiter; all outputs SHALL be registered.

Verification (INTERVAL=8, MAX_DEBT=4, URGENT=2 unless stated)
REQ-033 Bench SHALL cover idle refresh: no CPU_REQ, MEM_DONE 2 cycles after each grant -> first REF_GNT 9 cycles after reset release, REF_PENDING returns 0, REF_GNT recurs every 8 cycles.
REQ-034 Bench SHALL cover CPU priority: CPU_REQ held high, debt=1 -> CPU_GNT granted; after MEM_DONE, IDLE, then CPU_GNT again while debt<2.
REQ-035 Bench SHALL cover urgency: CPU_REQ held, withhold MEM_DONE until debt=2 -> on MEM_DONE, one IDLE cycle, then REF_GNT, not CPU_GNT.
REQ-036 Bench SHALL cover overflow: hold CPU grant without MEM_DONE for 40 cycles -> REF_PENDING saturates at 4, REF_OVERFLOW=1 and stays 1 after grants resume.
REQ-037 Bench SHALL cover tick/decrement coincidence: arrange IDLE->REF on a tick cycle with debt=1 -> REF_PENDING stays 1.
REQ-038 Bench SHALL cover reset mid-grant: assert RESET during REF_GNT -> next edge REF_GNT=0, REF_PENDING=0, REF_OVERFLOW=0; next tick 8 cycles after release.
